fsm_vedacao_multi: RTL and testbench

FSM_VEDACAO_MULTI -- requirements
Module: fsm_vedacao_multi

---
 rtl/vedacao_pkg.sv | 11 +
 rtl/vedacao_canal.sv | 46 ++++
 rtl/fsm_vedacao_multi.sv | 67 ++++++
 tb/tb_fsm_vedacao_multi.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vedacao_pkg.sv
// vedacao_pkg: channel state encoding and default seal duration for the multi-head sealer
package vedacao_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ESPERA    = 3'd1,
        VEDANDO   = 3'd2,
        CONCLUIDO = 3'd3,
        ABORTADO  = 3'd4
    } estado_t;
    localparam int TEMPO_VEDACAO_PADRAO = 25000000;
endpackage

// File: rtl/vedacao_canal.sv
// vedacao_canal: one sealing head, Moore FSM plus seal timer
module vedacao_canal
    import vedacao_pkg::*;
#(
    parameter int TEMPO_VEDACAO = TEMPO_VEDACAO_PADRAO
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cmd,
    input  logic grant,
    output logic espera,
    output logic vedacao_ativa,
    output logic tarefa_concluida,
    output logic erro_abortado
);
    localparam int TW = $clog2(TEMPO_VEDACAO + 1);
    estado_t estado, prox;
    logic [TW-1:0] timer;
    logic fim;
    assign fim = timer == TW'(TEMPO_VEDACAO - 1);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado <= IDLE;
            timer  <= '0;
        end else begin
            estado <= prox;
            timer  <= (estado == VEDANDO && prox == VEDANDO) ? timer + 1'b1 : '0;
        end
    end
    // Unused encodings fall to the default arm and recover to IDLE
    always_comb begin
        prox = IDLE;
        case (estado)
            IDLE:      prox = cmd ? ESPERA : IDLE;
            ESPERA:    prox = !cmd ? IDLE : grant ? VEDANDO : ESPERA;
            VEDANDO:   prox = !cmd ? ABORTADO : fim ? CONCLUIDO : VEDANDO;
            CONCLUIDO: prox = cmd ? CONCLUIDO : IDLE;
            ABORTADO:  prox = cmd ? ABORTADO : IDLE;
            default:   prox = IDLE;
        endcase
    end
    assign espera           = estado == ESPERA;
    assign vedacao_ativa    = estado == VEDANDO;
    assign tarefa_concluida = estado == CONCLUIDO;
    assign erro_abortado    = estado == ABORTADO;
endmodule

// File: rtl/fsm_vedacao_multi.sv
// fsm_vedacao_multi: N sealing heads sharing one cork magazine via round-robin grant
module fsm_vedacao_multi
    import vedacao_pkg::*;
#(
    parameter int N_CANAIS        = 2,
    parameter int TEMPO_VEDACAO   = TEMPO_VEDACAO_PADRAO,
    parameter int W_ROLHAS        = 8,
    parameter int ESTOQUE_INICIAL = 100
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_CANAIS-1:0] cmd_iniciar,
    input  logic                recarregar,
    output logic [N_CANAIS-1:0] vedacao_ativa,
    output logic [N_CANAIS-1:0] tarefa_concluida,
    output logic [N_CANAIS-1:0] erro_abortado,
    output logic [W_ROLHAS-1:0] estoque_rolhas,
    output logic                alarme_rolha
);
    localparam int PW = N_CANAIS > 1 ? $clog2(N_CANAIS) : 1;
    logic [N_CANAIS-1:0] espera, pedido, grant;
    logic [PW-1:0] ptr, sel, idx;
    logic achou, pode;
    // A head dropping its request this cycle must not consume a cork
    assign pedido = espera & cmd_iniciar;
    assign pode   = estoque_rolhas != '0 && !recarregar;
    always_comb begin
        grant = '0;
        sel   = ptr;
        idx   = ptr;
        achou = 1'b0;
        for (int o = 1; o <= N_CANAIS; o++) begin
            idx = PW'((int'(ptr) + o) % N_CANAIS);
            if (pode && !achou && pedido[idx]) begin
                achou      = 1'b1;
                grant[idx] = 1'b1;
                sel        = idx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr            <= PW'(N_CANAIS - 1);
            estoque_rolhas <= W_ROLHAS'(ESTOQUE_INICIAL);
        end else begin
            if (recarregar)
                estoque_rolhas <= W_ROLHAS'(ESTOQUE_INICIAL);
            else if (achou)
                estoque_rolhas <= estoque_rolhas - 1'b1;
            if (achou)
                ptr <= sel;
        end
    end
    assign alarme_rolha = estoque_rolhas == '0;
    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        vedacao_canal #(.TEMPO_VEDACAO(TEMPO_VEDACAO)) u_canal (
            .clk              (clk),
            .reset_n          (reset_n),
            .cmd              (cmd_iniciar[i]),
            .grant            (grant[i]),
            .espera           (espera[i]),
            .vedacao_ativa    (vedacao_ativa[i]),
            .tarefa_concluida (tarefa_concluida[i]),
            .erro_abortado    (erro_abortado[i])
        );
    end
endmodule

// File: tb/tb_fsm_vedacao_multi.sv
// tb_fsm_vedacao_multi: scenario bench with a queue of hand-derived expected outputs per edge
module tb_fsm_vedacao_multi;
    typedef struct packed {
        logic [1:0] va;
        logic [1:0] tc;
        logic [1:0] ea;
        logic [3:0] est;
        logic       al;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] cmd_iniciar = 2'b00;
    logic       recarregar = 1'b0;
    logic [1:0] vedacao_ativa, tarefa_concluida, erro_abortado;
    logic [3:0] estoque_rolhas;
    logic       alarme_rolha;
    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;

    fsm_vedacao_multi #(
        .N_CANAIS(2), .TEMPO_VEDACAO(4), .W_ROLHAS(4), .ESTOQUE_INICIAL(2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_iniciar      (cmd_iniciar),
        .recarregar       (recarregar),
        .vedacao_ativa    (vedacao_ativa),
        .tarefa_concluida (tarefa_concluida),
        .erro_abortado    (erro_abortado),
        .estoque_rolhas   (estoque_rolhas),
        .alarme_rolha     (alarme_rolha)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        return '{vedacao_ativa, tarefa_concluida, erro_abortado, estoque_rolhas, alarme_rolha};
    endfunction

    function automatic exp_t mk(logic [1:0] va, logic [1:0] tc, logic [1:0] ea, logic [3:0] est);
        return '{va, tc, ea, est, est == 4'd0};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        cmd_iniciar = 2'b00;
        recarregar = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t got, want;
        reset_n = 1'b0;
        cmd_iniciar = 2'b11;
        recarregar = 1'b1;
        sb.push_back(mk(2'b00, 2'b00, 2'b00, 4'd2));
        repeat (2) @(posedge clk);
        #1;
        got = obs();
        want = sb.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset: got %h expected %h", got, want);
        end
        do_reset();
    endtask

    task automatic test_single();
        exp_t got, want;
        do_reset();
        cmd_iniciar = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            if (e == 8) cmd_iniciar = 2'b00;
            sb.push_back(e == 8 ? mk(2'b00, 2'b00, 2'b00, 4'd1) :
                         mk((e >= 2 && e <= 5) ? 2'b01 : 2'b00, e >= 6 ? 2'b01 : 2'b00, 2'b00,
                            e >= 2 ? 4'd1 : 4'd2));
            @(posedge clk);
            #1;
            got = obs();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL single edge %0d: got va=%b tc=%b ea=%b est=%0d al=%b, expected va=%b tc=%b ea=%b est=%0d al=%b",
                         e, got.va, got.tc, got.ea, got.est, got.al, want.va, want.tc, want.ea, want.est, want.al);
            end
        end
    endtask

    task automatic test_both();
        exp_t got, want;
        logic [1:0] va;
        do_reset();
        cmd_iniciar = 2'b11;
        for (int e = 1; e <= 9; e++) begin
            if (e == 9) cmd_iniciar = 2'b00;
            va = {e >= 3 && e <= 6, e >= 2 && e <= 5};
            sb.push_back(e == 9 ? mk(2'b00, 2'b00, 2'b00, 4'd0) :
                         mk(va, {e >= 7, e >= 6}, 2'b00, e >= 3 ? 4'd0 : (e >= 2 ? 4'd1 : 4'd2)));
            @(posedge clk);
            #1;
            got = obs();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL both edge %0d: got va=%b tc=%b ea=%b est=%0d al=%b, expected va=%b tc=%b ea=%b est=%0d al=%b",
                         e, got.va, got.tc, got.ea, got.est, got.al, want.va, want.tc, want.ea, want.est, want.al);
            end
        end
    endtask

    // Runs straight after test_both: magazine is empty
    task automatic test_stock_zero();
        exp_t got, want;
        cmd_iniciar = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            recarregar = e == 4;
            if (e == 6) cmd_iniciar = 2'b00;
            sb.push_back(mk(e == 5 ? 2'b01 : 2'b00, 2'b00, e == 6 ? 2'b01 : 2'b00,
                            e >= 5 ? 4'd1 : (e == 4 ? 4'd2 : 4'd0)));
            @(posedge clk);
            #1;
            got = obs();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL stock_zero edge %0d: got va=%b tc=%b ea=%b est=%0d al=%b, expected va=%b tc=%b ea=%b est=%0d al=%b",
                         e, got.va, got.tc, got.ea, got.est, got.al, want.va, want.tc, want.ea, want.est, want.al);
            end
        end
        recarregar = 1'b0;
    endtask

    task automatic test_abort();
        exp_t got, want;
        do_reset();
        cmd_iniciar = 2'b01;
        for (int e = 1; e <= 6; e++) begin
            if (e == 4) cmd_iniciar = 2'b00;
            if (e == 5) cmd_iniciar = 2'b01;
            if (e == 6) cmd_iniciar = 2'b00;
            sb.push_back(mk((e == 2 || e == 3) ? 2'b01 : 2'b00, 2'b00,
                            (e == 4 || e == 5) ? 2'b01 : 2'b00, e >= 2 ? 4'd1 : 4'd2));
            @(posedge clk);
            #1;
            got = obs();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL abort edge %0d: got va=%b tc=%b ea=%b est=%0d al=%b, expected va=%b tc=%b ea=%b est=%0d al=%b",
                         e, got.va, got.tc, got.ea, got.est, got.al, want.va, want.tc, want.ea, want.est, want.al);
            end
        end
    endtask

    task automatic test_reload_conflict();
        exp_t got, want;
        do_reset();
        cmd_iniciar = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            recarregar = e == 2;
            if (e == 4) cmd_iniciar = 2'b00;
            sb.push_back(mk(e == 3 ? 2'b10 : 2'b00, 2'b00, e == 4 ? 2'b10 : 2'b00,
                            e >= 3 ? 4'd1 : 4'd2));
            @(posedge clk);
            #1;
            got = obs();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL reload_conflict edge %0d: got va=%b tc=%b ea=%b est=%0d al=%b, expected va=%b tc=%b ea=%b est=%0d al=%b",
                         e, got.va, got.tc, got.ea, got.est, got.al, want.va, want.tc, want.ea, want.est, want.al);
            end
        end
        recarregar = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t got, want;
        do_reset();
        cmd_iniciar = 2'b01;
        for (int e = 1; e <= 6; e++) begin
            reset_n = e != 4;
            sb.push_back(mk((e == 2 || e == 3 || e == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00,
                            (e == 2 || e == 3 || e == 6) ? 4'd1 : 4'd2));
            @(posedge clk);
            #1;
            got = obs();
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL reset_mid edge %0d: got va=%b tc=%b ea=%b est=%0d al=%b, expected va=%b tc=%b ea=%b est=%0d al=%b",
                         e, got.va, got.tc, got.ea, got.est, got.al, want.va, want.tc, want.ea, want.est, want.al);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_both();
        test_stock_zero();
        test_abort();
        test_reload_conflict();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
